ov7670_stream_gen: RTL and testbench



---
 rtl/ov7670_tx_pkg.sv | 43 ++++
 rtl/ov7670_pattern_gen.sv | 24 ++
 rtl/ov7670_stream_gen.sv | 172 +++++++++++++++++
 tb/tb_ov7670_stream_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_tx_pkg.sv
// Shared types and constants for the OV7670 DVP transmit-side generator.
package ov7670_tx_pkg;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } state_e;

    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_GRADIENT = 2'd1,
        PAT_CHECKER  = 2'd2,
        PAT_SOLID    = 2'd3
    } pattern_e;

    localparam rgb565_t BAR_WHITE   = 16'hFFFF;
    localparam rgb565_t BAR_YELLOW  = 16'hFFE0;
    localparam rgb565_t BAR_CYAN    = 16'h07FF;
    localparam rgb565_t BAR_GREEN   = 16'h07E0;
    localparam rgb565_t BAR_MAGENTA = 16'hF81F;
    localparam rgb565_t BAR_RED     = 16'hF800;
    localparam rgb565_t BAR_BLUE    = 16'h001F;
    localparam rgb565_t BAR_BLACK   = 16'h0000;

    function automatic rgb565_t bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = BAR_WHITE;
            3'd1:    bar_color = BAR_YELLOW;
            3'd2:    bar_color = BAR_CYAN;
            3'd3:    bar_color = BAR_GREEN;
            3'd4:    bar_color = BAR_MAGENTA;
            3'd5:    bar_color = BAR_RED;
            3'd6:    bar_color = BAR_BLUE;
            default: bar_color = BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/ov7670_pattern_gen.sv
// Combinational test-pattern source: maps pixel position and frame context to an RGB565 value.
module ov7670_pattern_gen
    import ov7670_tx_pkg::*;
(
    input  logic [4:0] x_i,
    input  logic [5:0] y_i,
    input  logic [2:0] bar_idx_i,
    input  pattern_e   pattern_i,
    input  rgb565_t    solid_i,
    input  logic [4:0] frame_cnt_i,
    output rgb565_t    rgb_o
);

    always_comb begin
        rgb_o = '0;
        case (pattern_i)
            PAT_BARS:     rgb_o = bar_color(bar_idx_i);
            PAT_GRADIENT: rgb_o = {x_i, y_i, frame_cnt_i};
            PAT_CHECKER:  rgb_o = (x_i[3] ^ y_i[3]) ? 16'hFFFF : 16'h0000;
            default:      rgb_o = solid_i;
        endcase
    end

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670 DVP transmitter: emits PCLK/VSYNC/HREF/D with VGA-style frame timing and RGB565 test patterns.
module ov7670_stream_gen
    import ov7670_tx_pkg::*;
#(
    parameter int   H_ACTIVE     = 640,
    parameter int   H_BLANK      = 144,
    parameter int   V_ACTIVE     = 480,
    parameter int   VSYNC_LINES  = 3,
    parameter int   V_BACK       = 17,
    parameter int   V_FRONT      = 10,
    parameter logic VSYNC_ACTIVE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_rgb,
    output logic        pclk,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  d,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output state_e      dbg_state
);

    localparam int SLOTS      = 2 * (H_ACTIVE + H_BLANK);
    localparam int HREF_SLOTS = 2 * H_ACTIVE;
    localparam int BAR_PIX    = H_ACTIVE / 8;

    function automatic logic [15:0] lines_in(input state_e s);
        case (s)
            VSYNC:   lines_in = 16'(VSYNC_LINES);
            VBACK:   lines_in = 16'(V_BACK);
            ACTIVE:  lines_in = 16'(V_ACTIVE);
            VFRONT:  lines_in = 16'(V_FRONT);
            default: lines_in = 16'd1;
        endcase
    endfunction

    state_e      state_q, state_d;
    pattern_e    pat_q;
    rgb565_t     solid_q, rgb;
    logic        pclk_q, vsync_q, href_q, busy_q, frame_done_q;
    logic [7:0]  d_q;
    logic [15:0] frame_cnt_q;
    logic [15:0] slot_q, slot_d, line_q, line_d, bar_cnt_q, bar_cnt_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic        start_frame, last_slot, last_line, last_clk, href_d;

    assign last_slot = (slot_q == 16'(SLOTS - 1));
    assign last_line = (line_q == lines_in(state_q) - 16'd1);
    // Last clk of a frame is the pclk-high half of the final VFRONT slot.
    assign last_clk  = !pclk_q && (state_q == VFRONT) && last_slot && last_line;

    // Position is advanced only at slot boundaries (pclk high -> low), so *_d
    // describe the slot whose outputs are being loaded.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        line_d      = line_q;
        bar_cnt_d   = bar_cnt_q;
        bar_idx_d   = bar_idx_q;
        start_frame = 1'b0;
        if (pclk_q) begin
            if (state_q == IDLE) begin
                if (enable) begin
                    state_d     = VSYNC;
                    slot_d      = '0;
                    line_d      = '0;
                    start_frame = 1'b1;
                end
            end else if (!last_slot) begin
                slot_d = slot_q + 16'd1;
            end else begin
                slot_d = '0;
                if (!last_line) begin
                    line_d = line_q + 16'd1;
                end else begin
                    line_d = '0;
                    case (state_q)
                        VSYNC:  state_d = VBACK;
                        VBACK:  state_d = ACTIVE;
                        ACTIVE: state_d = VFRONT;
                        default: begin
                            if (enable) begin
                                state_d     = VSYNC;
                                start_frame = 1'b1;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    endcase
                end
            end
            if (slot_d == 16'd0) begin
                bar_cnt_d = '0;
                bar_idx_d = '0;
            end else if (!slot_d[0]) begin
                if (bar_cnt_q == 16'(BAR_PIX - 1)) begin
                    bar_cnt_d = '0;
                    bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_cnt_d = bar_cnt_q + 16'd1;
                end
            end
        end
    end

    assign href_d = (state_d == ACTIVE) && (slot_d < 16'(HREF_SLOTS));

    ov7670_pattern_gen u_pattern (
        .x_i         (slot_d[5:1]),
        .y_i         (line_d[5:0]),
        .bar_idx_i   (bar_idx_d),
        .pattern_i   (pat_q),
        .solid_i     (solid_q),
        .frame_cnt_i (frame_cnt_q[4:0]),
        .rgb_o       (rgb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pclk_q       <= 1'b0;
            slot_q       <= '0;
            line_q       <= '0;
            bar_cnt_q    <= '0;
            bar_idx_q    <= '0;
            pat_q        <= PAT_BARS;
            solid_q      <= '0;
            vsync_q      <= ~VSYNC_ACTIVE;
            href_q       <= 1'b0;
            d_q          <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            pclk_q       <= ~pclk_q;
            state_q      <= state_d;
            slot_q       <= slot_d;
            line_q       <= line_d;
            bar_cnt_q    <= bar_cnt_d;
            bar_idx_q    <= bar_idx_d;
            frame_done_q <= last_clk;
            if (last_clk) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (start_frame) begin
                pat_q   <= pattern_e'(pattern_sel);
                solid_q <= solid_rgb;
            end
            if (pclk_q) begin
                vsync_q <= (state_d == VSYNC) ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
                href_q  <= href_d;
                d_q     <= href_d ? (slot_d[0] ? rgb[7:0] : rgb[15:8]) : 8'h00;
                busy_q  <= (state_d != IDLE);
            end
        end
    end

    assign pclk       = pclk_q;
    assign vsync      = vsync_q;
    assign href       = href_q;
    assign d          = d_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Directed bench for ov7670_stream_gen on a reduced 8x2 frame with a byte scoreboard and capture buffer.
module tb_ov7670_stream_gen;
  import ov7670_tx_pkg::*;

  localparam int HA = 8, HB = 2, VA = 2, VS = 1, VB = 1, VF = 1;
  localparam int LINE_CLK  = 4 * (HA + HB);
  localparam int FRAME_CLK = LINE_CLK * (VS + VB + VA + VF);

  // clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] solid_rgb = 16'h0000;
  logic        pclk, vsync, href, busy, frame_done;
  logic [7:0]  d;
  logic [15:0] frame_cnt;
  state_e      dbg_state;

  always #5 clk = ~clk;

  ov7670_stream_gen #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF), .VSYNC_ACTIVE(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .solid_rgb(solid_rgb), .pclk(pclk), .vsync(vsync), .href(href), .d(d),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt), .dbg_state(dbg_state)
  );

  // scoreboard
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q[$];
  logic        mon_en = 1'b1;
  int          cap_idx = 0;
  logic        cap_hi = 1'b1;
  logic [7:0]  cap_hi_byte;
  logic [15:0] cap_buf[16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_pix(input int pat, input int x, input int y,
                                            input logic [15:0] solid, input logic [15:0] fc);
    logic [15:0] xb, yb;
    xb = 16'(x);
    yb = 16'(y);
    case (pat)
      0: case (x / (HA / 8))
           0: model_pix = 16'hFFFF;
           1: model_pix = 16'hFFE0;
           2: model_pix = 16'h07FF;
           3: model_pix = 16'h07E0;
           4: model_pix = 16'hF81F;
           5: model_pix = 16'hF800;
           6: model_pix = 16'h001F;
           default: model_pix = 16'h0000;
         endcase
      1: model_pix = {xb[4:0], yb[5:0], fc[4:0]};
      2: model_pix = (xb[3] ^ yb[3]) ? 16'hFFFF : 16'h0000;
      default: model_pix = solid;
    endcase
  endfunction

  task automatic push_frame(input int pat, input logic [15:0] solid, input logic [15:0] fc);
    logic [15:0] px;
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        px = model_pix(pat, x, y, solid, fc);
        exp_q.push_back(px[15:8]);
        exp_q.push_back(px[7:0]);
      end
    end
  endtask

  // monitor: one sample per byte slot, taken mid-way through the pclk-high clk
  always @(negedge clk) begin
    if (rst_n && vsync) begin
      cap_idx = 0;
      cap_hi  = 1'b1;
    end
    if (rst_n && pclk && href) begin
      if (cap_hi) begin
        cap_hi_byte = d;
        cap_hi = 1'b0;
      end else begin
        if (cap_idx < 16) cap_buf[cap_idx] = {cap_hi_byte, d};
        cap_idx++;
        cap_hi = 1'b1;
      end
      if (mon_en) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL byte_stream: observed extra byte %0h expected none", d);
        end
        if (exp_q.size() != 0) chk("byte_stream", {24'd0, d}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic wait_vsync(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (vsync !== 1'b1 && n < 8);
    chk(tag, {31'd0, vsync}, 32'd1);
  endtask

  // Checks frame timing for nframes back-to-back frames starting at the vsync sample.
  task automatic profile(input string tag, input int nframes, input int drop_at, input logic [15:0] fc0);
    int e_vs, e_hr, e_fd, e_bz, e_pc, e_d0, e_fc;
    int kk, ln, lp;
    logic ev, eh;
    e_vs = 0; e_hr = 0; e_fd = 0; e_bz = 0; e_pc = 0; e_d0 = 0; e_fc = 0;
    for (int k = 0; k < nframes * FRAME_CLK; k++) begin
      if (k > 0) @(negedge clk);
      if (k == drop_at) begin
        enable = 1'b0;
        pattern_sel = pattern_sel ^ 2'b11;
        solid_rgb = 16'hABCD;
      end
      kk = k % FRAME_CLK;
      ln = kk / LINE_CLK;
      lp = kk % LINE_CLK;
      ev = (ln < VS);
      eh = (ln >= VS + VB) && (ln < VS + VB + VA) && (lp < 4 * HA);
      if (vsync !== ev) e_vs++;
      if (href !== eh) e_hr++;
      if (frame_done !== (kk == FRAME_CLK - 1)) e_fd++;
      if (busy !== 1'b1) e_bz++;
      if (pclk !== k[0]) e_pc++;
      if (!eh && d !== 8'h00) e_d0++;
      if (kk == FRAME_CLK - 1 && frame_cnt !== fc0 + 16'(k / FRAME_CLK) + 16'd1) e_fc++;
    end
    chk({tag, "_vsync_errs"}, e_vs, 0);
    chk({tag, "_href_errs"}, e_hr, 0);
    chk({tag, "_frame_done_errs"}, e_fd, 0);
    chk({tag, "_busy_errs"}, e_bz, 0);
    chk({tag, "_pclk_errs"}, e_pc, 0);
    chk({tag, "_d_blank_errs"}, e_d0, 0);
    chk({tag, "_frame_cnt_errs"}, e_fc, 0);
    @(negedge clk);
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_state_after"}, 32'(dbg_state), 32'(IDLE));
    chk({tag, "_frame_cnt_after"}, {16'd0, frame_cnt}, {16'd0, fc0 + 16'(nframes)});
    chk({tag, "_exp_q_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pclk"}, {31'd0, pclk}, 32'd0);
    chk({tag, "_vsync"}, {31'd0, vsync}, 32'd0);
    chk({tag, "_href"}, {31'd0, href}, 32'd0);
    chk({tag, "_d"}, {24'd0, d}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    chk({tag, "_frame_cnt"}, {16'd0, frame_cnt}, 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // directed sequence
  initial begin
    int toggles, n;
    logic prev;

    // reset and idle
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    prev = pclk;
    toggles = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pclk !== prev) toggles++;
      prev = pclk;
      if (vsync !== 1'b0 || href !== 1'b0 || d !== 8'h00 || busy !== 1'b0) toggles = -100;
    end
    chk("idle_pclk_toggle", toggles, 6);

    // colour bars, single frame
    pattern_sel = 2'd0;
    push_frame(0, 16'h0000, 16'd0);
    enable = 1'b1;
    wait_vsync("bars_vsync_start");
    profile("bars", 1, 5, 16'd0);

    // solid, with inputs changed mid-frame
    pattern_sel = 2'd3;
    solid_rgb = 16'h1234;
    push_frame(3, 16'h1234, 16'd0);
    @(negedge clk);
    enable = 1'b1;
    wait_vsync("solid_vsync_start");
    profile("solid", 1, 5, 16'd1);

    // gradient, back-to-back frames, enable dropped mid frame 4
    pattern_sel = 2'd1;
    for (int f = 0; f < 4; f++) push_frame(1, 16'h0000, 16'(2 + f));
    @(negedge clk);
    enable = 1'b1;
    wait_vsync("grad_vsync_start");
    profile("grad", 4, 3 * FRAME_CLK + 50, 16'd2);

    // reset in the middle of an active line
    mon_en = 1'b0;
    pattern_sel = 2'd2;
    enable = 1'b1;
    wait_vsync("rst_mid_vsync_start");
    n = 0;
    while (href !== 1'b1 && n < FRAME_CLK) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached_href", {31'd0, href}, 32'd1);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    exp_q.delete();
    for (int i = 0; i < 16; i++) cap_buf[i] = 16'h5A5A;
    rst_n = 1'b1;
    push_frame(2, 16'h0000, 16'd0);
    mon_en = 1'b1;
    wait_vsync("chk_vsync_start");
    profile("chk", 1, 5, 16'd0);
    chk("chk_cap_count", cap_idx, 16);
    for (int i = 0; i < 16; i++) begin
      chk("chk_cap_pixel", {16'd0, cap_buf[i]}, {16'd0, model_pix(2, i % HA, i / HA, 16'h0000, 16'd0)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
